// File: rtl/flatten_buffer_if.sv
// flatten_buffer_if: handshake bundle between pooled-pixel producers, the flatten buffer and its consumer.
//   in_valid/in_data/in_ready : per-kernel pixel strobes, shared data lanes, write-accept
//   out_valid/out_data/out_ready/out_last : flattened word stream, last word of frame
//   overflow/lane_conflict    : sticky error flags
interface flatten_buffer_if #(
   parameter int BitSize            = 32,
   parameter int NumberOfK          = 4,
   parameter int ProcessingElements = 2
);
   logic [NumberOfK-1:0]                         in_valid;
   logic [ProcessingElements-1:0][BitSize-1:0]   in_data;
   logic                                         in_ready;
   logic                                         out_valid;
   logic [BitSize-1:0]                           out_data;
   logic                                         out_ready;
   logic                                         out_last;
   logic                                         overflow;
   logic                                         lane_conflict;
   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, overflow, lane_conflict
   );
   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, overflow, lane_conflict
   );
endinterface

// File: rtl/flatten_buffer.sv
// flatten_buffer: collects NumberOfK pooled feature maps, then streams them out channel-major.
//   clk, rst : clock, synchronous active-high reset
//   bus      : flatten_buffer_if.slave (pixel inputs, word stream output, sticky error flags)
module flatten_buffer #(
   parameter int BitSize            = 32,
   parameter int NumberOfK          = 4,
   parameter int ProcessingElements = 2,
   parameter int ImageWidth         = 2
) (
   input logic            clk,
   input logic            rst,
   flatten_buffer_if.slave bus
);
   localparam int P     = ImageWidth * ImageWidth;
   localparam int Depth = NumberOfK * P;
   localparam int AW    = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CW    = $clog2(P + 1);

   typedef enum logic {FILL, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q [NumberOfK];
   logic [CW-1:0]        cnt_d [NumberOfK];
   logic [AW-1:0]        rd_addr_q, rd_addr_d;
   logic                 overflow_q, overflow_d;
   logic                 conflict_q, conflict_d;
   logic [BitSize-1:0]   mem_q [Depth];
   logic [NumberOfK-1:0] clash, wr;
   logic                 fill, last, done, all_full, ovf;

   // A kernel clashes when any other strobed kernel shares its data lane.
   always_comb begin
      clash = '0;
      for (int k = 0; k < NumberOfK; k++)
         for (int j = 0; j < NumberOfK; j++)
            if (j != k && (j % ProcessingElements) == (k % ProcessingElements) && bus.in_valid[j] && bus.in_valid[k])
               clash[k] = 1'b1;
   end

   always_comb begin
      fill      = state_q == FILL;
      last      = !fill && rd_addr_q == AW'(Depth - 1);
      done      = last && bus.out_ready;
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      cnt_d     = cnt_q;
      wr        = '0;
      ovf       = 1'b0;
      all_full  = 1'b1;
      for (int k = 0; k < NumberOfK; k++) begin
         wr[k]    = fill && bus.in_valid[k] && !clash[k] && cnt_q[k] != CW'(P);
         cnt_d[k] = done ? '0 : cnt_q[k] + CW'(wr[k]);
         ovf      = ovf | (bus.in_valid[k] && (!fill || cnt_q[k] == CW'(P)));
         all_full = all_full && cnt_d[k] == CW'(P);
      end
      // Entering DRAIN off the next-state counters puts word 0 out the cycle after the last write.
      if (fill && all_full) state_d = DRAIN;
      else if (done) begin
         state_d   = FILL;
         rd_addr_d = '0;
      end else if (!fill && bus.out_ready) rd_addr_d = rd_addr_q + AW'(1);
      overflow_d = overflow_q | ovf;
      conflict_d = conflict_q | (fill && |clash);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FILL;
         rd_addr_q  <= '0;
         overflow_q <= 1'b0;
         conflict_q <= 1'b0;
         for (int k = 0; k < NumberOfK; k++) cnt_q[k] <= '0;
      end else begin
         state_q    <= state_d;
         rd_addr_q  <= rd_addr_d;
         overflow_q <= overflow_d;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         for (int k = 0; k < NumberOfK; k++)
            if (wr[k]) mem_q[AW'(k * P + int'(cnt_q[k]))] <= bus.in_data[k % ProcessingElements];
   end

   assign bus.in_ready      = fill;
   assign bus.out_valid     = !fill;
   assign bus.out_last      = last;
   assign bus.out_data      = mem_q[rd_addr_q];
   assign bus.overflow      = overflow_q;
   assign bus.lane_conflict = conflict_q;
endmodule

// File: tb/tb_flatten_buffer.sv
// tb_flatten_buffer: directed, table-driven bench for flatten_buffer at default parameters.
module tb_flatten_buffer;
   typedef struct {
      logic [3:0]  iv;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        rdy;
   } fill_vec_t;

   logic      clk = 1'b0;
   logic      rst = 1'b1;
   int        tests = 0;
   int        fails = 0;
   fill_vec_t tbl [8];

   flatten_buffer_if #(.BitSize(32), .NumberOfK(4), .ProcessingElements(2)) bus ();

   flatten_buffer #(.BitSize(32), .NumberOfK(4), .ProcessingElements(2), .ImageWidth(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", 32'(bus.in_ready), 1);
      check("rst_out_valid", 32'(bus.out_valid), 0);
      check("rst_out_last", 32'(bus.out_last), 0);
      check("rst_overflow", 32'(bus.overflow), 0);
      check("rst_lane_conflict", 32'(bus.lane_conflict), 0);
   endtask

   // inject: 0 none, 1 fifth k0 pixel before the final vector, 2 lane0 clash before the first vector
   task automatic fill_frame(input logic [31:0] base, input int inject);
      for (int i = 0; i < 8; i++) begin
         if (inject == 2 && i == 0) begin
            bus.in_valid   = 4'b0101;
            bus.in_data[0] = 32'hBAD0;
            bus.in_data[1] = 32'hBAD1;
            step();
            check("conflict_flag", 32'(bus.lane_conflict), 1);
            check("conflict_in_ready", 32'(bus.in_ready), 1);
         end
         if (inject == 1 && i == 7) begin
            bus.in_valid   = 4'b0001;
            bus.in_data[0] = 32'hDEAD;
            step();
            check("overflow_flag", 32'(bus.overflow), 1);
            check("overflow_in_ready", 32'(bus.in_ready), 1);
         end
         bus.in_valid   = tbl[i].iv;
         bus.in_data[0] = base + tbl[i].d0;
         bus.in_data[1] = base + tbl[i].d1;
         check("fill_in_ready", 32'(bus.in_ready), 32'(tbl[i].rdy));
         step();
      end
      bus.in_valid = '0;
      check("drain_entry_valid", 32'(bus.out_valid), 1);
      check("drain_entry_in_ready", 32'(bus.in_ready), 0);
      check("drain_entry_word0", bus.out_data, base);
   endtask

   task automatic drain(input logic [31:0] base, input int n, input bit toggle);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < 400) begin
         bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
         if (bus.out_valid && bus.out_ready) begin
            check("drain_word", bus.out_data, base + 32'(16 * (idx / 4) + idx % 4));
            check("drain_last", 32'(bus.out_last), 32'(idx == 15));
            check("drain_in_ready", 32'(bus.in_ready), 0);
            idx++;
         end
         step();
         cyc++;
      end
      bus.out_ready = 1'b0;
      if (idx < n) check("drain_timeout", 32'(idx), 32'(n));
      if (n == 16) begin
         check("post_last_in_ready", 32'(bus.in_ready), 1);
         check("post_last_out_valid", 32'(bus.out_valid), 0);
      end
   endtask

   initial begin
      tbl[0] = '{4'b0011, 32'h00, 32'h10, 1'b1};
      tbl[1] = '{4'b1100, 32'h20, 32'h30, 1'b1};
      tbl[2] = '{4'b0011, 32'h01, 32'h11, 1'b1};
      tbl[3] = '{4'b1100, 32'h21, 32'h31, 1'b1};
      tbl[4] = '{4'b0011, 32'h02, 32'h12, 1'b1};
      tbl[5] = '{4'b1100, 32'h22, 32'h32, 1'b1};
      tbl[6] = '{4'b0011, 32'h03, 32'h13, 1'b1};
      tbl[7] = '{4'b1100, 32'h23, 32'h33, 1'b1};
      bus.in_valid  = '0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      do_reset();
      fill_frame(32'h0, 0);
      drain(32'h0, 16, 1'b0);
      check("clean_overflow", 32'(bus.overflow), 0);
      check("clean_lane_conflict", 32'(bus.lane_conflict), 0);

      fill_frame(32'h100, 0);
      drain(32'h100, 16, 1'b0);

      fill_frame(32'h200, 0);
      for (int c = 0; c < 5; c++) begin
         bus.in_valid = (c == 2) ? 4'b0001 : 4'b0000;
         bus.in_data[0] = 32'hFFFF;
         check("hold_valid", 32'(bus.out_valid), 1);
         check("hold_word0", bus.out_data, 32'h200);
         step();
      end
      bus.in_valid = '0;
      check("drain_overflow", 32'(bus.overflow), 1);
      drain(32'h200, 16, 1'b1);

      do_reset();
      fill_frame(32'h300, 1);
      check("ovf_no_conflict", 32'(bus.lane_conflict), 0);
      drain(32'h300, 16, 1'b0);
      check("ovf_sticky", 32'(bus.overflow), 1);

      do_reset();
      fill_frame(32'h400, 2);
      check("conf_no_overflow", 32'(bus.overflow), 0);
      drain(32'h400, 16, 1'b0);
      check("conf_sticky", 32'(bus.lane_conflict), 1);

      do_reset();
      fill_frame(32'h500, 0);
      drain(32'h500, 7, 1'b0);
      rst            = 1'b1;
      bus.in_valid   = 4'b1111;
      bus.in_data[0] = 32'hEEEE;
      bus.in_data[1] = 32'hEEEE;
      step();
      rst          = 1'b0;
      bus.in_valid = '0;
      check("abort_out_valid", 32'(bus.out_valid), 0);
      check("abort_in_ready", 32'(bus.in_ready), 1);
      check("abort_out_last", 32'(bus.out_last), 0);
      fill_frame(32'h600, 0);
      drain(32'h600, 16, 1'b0);
      check("abort_overflow", 32'(bus.overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
